load_store_unit: RTL and testbench

- Initiator side of the data memory port: turns pipeline load/store requests into word-indexed MemRead/MemWrite accesses on a 64-bit-wide, 1024-entry data memory.
- Handles RISC-V byte, half, word and double sizes, little-endian, with sign or zero extension on loads.
- Sub-doubleword stores use read-modify-write.
- Sits between the MEM pipeline stage and data_memory; reports misaligned, out-of-range and illegal-size requests.

---
 rtl/load_store_unit.sv | 173 +++++++++++++++++
 tb/tb_load_store_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store initiator for a 64-bit word-indexed data memory.
// Sub-doubleword stores use read-modify-write; loads are little-endian with sign/zero extension.
module load_store_unit #(
    parameter int unsigned MEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [63:0] mem_address,
    output logic [63:0] mem_write_data,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [63:0] mem_read_data
);

    localparam int unsigned XW    = 64;
    localparam int unsigned IDX_W = 61;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_RD  = 3'd1,
        STORE_RD = 3'd2,
        STORE_WR = 3'd3,
        RESP     = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [2:0]    funct3_q;
    logic [2:0]    off_q;
    logic [XW-1:0] wdata_q;

    logic          accept_c;
    logic          req_err_c;
    logic          misalign_c;
    logic [5:0]    shamt_c;
    logic [XW-1:0] lane_c;
    logic [XW-1:0] load_ext_c;
    logic [XW-1:0] mask_c;
    logic [XW-1:0] merge_c;

    assign accept_c = req_valid & req_ready;

    // Request legality: alignment, memory range, encodable size
    always_comb begin
        misalign_c = 1'b0;
        case (req_funct3[1:0])
            2'b01:   misalign_c = req_addr[0];
            2'b10:   misalign_c = |req_addr[1:0];
            2'b11:   misalign_c = |req_addr[2:0];
            default: misalign_c = 1'b0;
        endcase
        req_err_c = misalign_c
                  | (req_addr[63:3] >= IDX_W'(MEM_DEPTH))
                  | (!req_is_store && (req_funct3 == 3'b111))
                  | (req_is_store && req_funct3[2]);
    end

    // Lane extraction for loads and byte-lane merge for sub-doubleword stores
    assign shamt_c = {off_q, 3'b000};
    assign lane_c  = mem_read_data >> shamt_c;

    always_comb begin
        load_ext_c = lane_c;
        mask_c     = '1;
        case (funct3_q[1:0])
            2'b00: begin
                load_ext_c = {{56{~funct3_q[2] & lane_c[7]}}, lane_c[7:0]};
                mask_c     = XW'(64'h0000_0000_0000_00FF);
            end
            2'b01: begin
                load_ext_c = {{48{~funct3_q[2] & lane_c[15]}}, lane_c[15:0]};
                mask_c     = XW'(64'h0000_0000_0000_FFFF);
            end
            2'b10: begin
                load_ext_c = {{32{~funct3_q[2] & lane_c[31]}}, lane_c[31:0]};
                mask_c     = XW'(64'h0000_0000_FFFF_FFFF);
            end
            default: begin
                load_ext_c = lane_c;
                mask_c     = '1;
            end
        endcase
        merge_c = (mem_read_data & ~(mask_c << shamt_c))
                | ((wdata_q << shamt_c) & (mask_c << shamt_c));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and state-decoded strobes
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept_c) begin
                    if (req_err_c)                   state_nxt = RESP;
                    else if (!req_is_store)          state_nxt = LOAD_RD;
                    else if (req_funct3[1:0] == 2'b11) state_nxt = STORE_WR;
                    else                             state_nxt = STORE_RD;
                end
            end
            LOAD_RD: begin
                MemRead   = 1'b1;
                state_nxt = RESP;
            end
            STORE_RD: begin
                MemRead   = 1'b1;
                state_nxt = STORE_WR;
            end
            STORE_WR: begin
                MemWrite  = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct3_q       <= '0;
            off_q          <= '0;
            wdata_q        <= '0;
            resp_err       <= 1'b0;
            resp_rdata     <= '0;
            mem_address    <= '0;
            mem_write_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        funct3_q    <= req_funct3;
                        off_q       <= req_addr[2:0];
                        wdata_q     <= req_wdata;
                        resp_err    <= req_err_c;
                        resp_rdata  <= '0;
                        mem_address <= {3'b000, req_addr[63:3]};
                        if (req_is_store && (req_funct3[1:0] == 2'b11))
                            mem_write_data <= req_wdata;
                    end
                end
                LOAD_RD:  resp_rdata     <= load_ext_c;
                STORE_RD: mem_write_data <= merge_c;
                RESP: begin
                    mem_address <= '0;
                    resp_err    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 1024x64 data memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [63:0] mem_address;
    logic [63:0] mem_write_data;
    logic        MemWrite;
    logic        MemRead;
    logic [63:0] mem_read_data;

    logic [63:0] mem [0:1023];
    int          total = 0;
    int          bad   = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          both_cnt = 0;
    logic [63:0] last_wr_addr = '0;

    load_store_unit #(.MEM_DEPTH(1024)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_is_store   (req_is_store),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .MemWrite       (MemWrite),
        .MemRead        (MemRead),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_address[9:0]];

    always @(posedge clk) begin
        if (MemWrite) mem[mem_address[9:0]] <= mem_write_data;
    end

    always @(negedge clk) begin
        if (MemRead)  rd_cnt++;
        if (MemWrite) begin
            wr_cnt++;
            last_wr_addr = mem_address;
        end
        if (MemRead && MemWrite) both_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One request: drive at negedge, accept at posedge, scramble inputs, wait for the response
    task automatic txn(input string tag, input logic st, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] wd,
                       input logic [63:0] exp_rd, input logic exp_err, input int exp_lat,
                       input int exp_nrd, input int exp_nwr);
        int          rd0;
        int          wr0;
        int          lat;
        logic [63:0] rd;
        logic        er;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        lat = 0;
        rd  = '0;
        er  = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_is_store = ~st; req_funct3 = 3'b111;
        req_addr = 64'hDEAD_BEEF_DEAD_BEEF; req_wdata = ~wd;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = i; rd = resp_rdata; er = resp_err;
                break;
            end
        end
        chk({tag, "/lat"},   64'(lat), 64'(exp_lat));
        chk({tag, "/rdata"}, rd, exp_rd);
        chk({tag, "/err"},   64'(er), 64'(exp_err));
        chk({tag, "/nrd"},   64'(rd_cnt - rd0), 64'(exp_nrd));
        chk({tag, "/nwr"},   64'(wr_cnt - wr0), 64'(exp_nwr));
    endtask

    logic [5:0]  rv_seq;
    logic [5:0]  rdy_seq;
    logic [63:0] b2b_rd;
    int          late_resp;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0;
        req_funct3 = '0; req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst/ready",  64'(req_ready), 64'd1);
        chk("rst/rvalid", 64'(resp_valid), 64'd0);
        chk("rst/rdata",  resp_rdata, 64'd0);
        chk("rst/memrd",  64'(MemRead), 64'd0);
        chk("rst/memwr",  64'(MemWrite), 64'd0);
        chk("rst/addr",   mem_address, 64'd0);
        chk("rst/wdata",  mem_write_data, 64'd0);
        rst_n = 1'b1;

        txn("sd", 1'b1, 3'b011, 64'h10, 64'h1122_3344_5566_7788, 64'd0, 1'b0, 2, 0, 1);
        chk("sd/wraddr", last_wr_addr, 64'd2);
        chk("sd/mem", mem[2], 64'h1122_3344_5566_7788);
        txn("ld", 1'b0, 3'b011, 64'h10, 64'd0, 64'h1122_3344_5566_7788, 1'b0, 2, 1, 0);
        @(negedge clk);
        chk("idle/addr", mem_address, 64'd0);

        txn("sb", 1'b1, 3'b000, 64'h13, 64'hAB, 64'd0, 1'b0, 3, 1, 1);
        chk("sb/mem", mem[2], 64'h1122_3344_AB66_7788);
        txn("lb",  1'b0, 3'b000, 64'h13, 64'd0, 64'hFFFF_FFFF_FFFF_FFAB, 1'b0, 2, 1, 0);
        txn("lbu", 1'b0, 3'b100, 64'h13, 64'd0, 64'h0000_0000_0000_00AB, 1'b0, 2, 1, 0);

        mem[1] = 64'h8000_0000_0000_8000;
        txn("lh",  1'b0, 3'b001, 64'h8, 64'd0, 64'hFFFF_FFFF_FFFF_8000, 1'b0, 2, 1, 0);
        txn("lwu", 1'b0, 3'b110, 64'hC, 64'd0, 64'h0000_0000_8000_0000, 1'b0, 2, 1, 0);
        txn("lw",  1'b0, 3'b010, 64'hC, 64'd0, 64'hFFFF_FFFF_8000_0000, 1'b0, 2, 1, 0);

        mem[3] = 64'h0123_4567_89AB_CDEF;
        txn("e_lh",  1'b0, 3'b001, 64'h3,    64'd0, 64'd0, 1'b1, 1, 0, 0);
        txn("e_sw",  1'b1, 3'b010, 64'h6,    64'hFFFF_FFFF, 64'd0, 1'b1, 1, 0, 0);
        txn("e_rng", 1'b0, 3'b011, 64'h2000, 64'd0, 64'd0, 1'b1, 1, 0, 0);
        txn("e_ld7", 1'b0, 3'b111, 64'h0,    64'd0, 64'd0, 1'b1, 1, 0, 0);
        txn("e_st4", 1'b1, 3'b100, 64'h18,   64'hFF, 64'd0, 1'b1, 1, 0, 0);
        chk("err/mem0", mem[0], 64'd0);
        chk("err/mem3", mem[3], 64'h0123_4567_89AB_CDEF);

        // Back-to-back: sh then ld with req_valid held high throughout
        mem[5] = '1;
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b001;
        req_addr = 64'h28; req_wdata = 64'h1234_BEEF;
        @(posedge clk);
        #1;
        req_is_store = 1'b0; req_funct3 = 3'b011;
        rv_seq = '0; rdy_seq = '0; b2b_rd = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rv_seq[i]  = resp_valid;
            rdy_seq[i] = req_ready;
            if (i == 4) req_valid = 1'b0;
            if (i == 5) b2b_rd = resp_rdata;
        end
        chk("b2b/rvalid", 64'(rv_seq), 64'(6'b100100));
        chk("b2b/ready",  64'(rdy_seq), 64'(6'b001000));
        chk("b2b/mem",    mem[5], 64'hFFFF_FFFF_FFFF_BEEF);
        chk("b2b/ld",     b2b_rd, 64'hFFFF_FFFF_FFFF_BEEF);

        // Reset during STORE_WR aborts the write and the response
        mem[4] = 64'hCAFE_F00D_0BAD_BEEF;
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010;
        req_addr = 64'h20; req_wdata = 64'h1234_5678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort/inwr", 64'(MemWrite), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort/memwr",  64'(MemWrite), 64'd0);
        chk("abort/memrd",  64'(MemRead), 64'd0);
        chk("abort/rvalid", 64'(resp_valid), 64'd0);
        chk("abort/addr",   mem_address, 64'd0);
        chk("abort/wdata",  mem_write_data, 64'd0);
        chk("abort/rdata",  resp_rdata, 64'd0);
        chk("abort/err",    64'(resp_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        late_resp = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) late_resp++;
        end
        chk("abort/noresp", 64'(late_resp), 64'd0);
        chk("abort/mem4",   mem[4], 64'hCAFE_F00D_0BAD_BEEF);
        chk("abort/ready",  64'(req_ready), 64'd1);
        chk("rdwr_overlap", 64'(both_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
